pll_reset_sequencer: RTL and testbench

Converts the raw, asynchronous `locked` flag of a board PLL into a clean, synchronous active-high reset and a `ready` flag for the logic clocked by one PLL output clock. The flag must stay continuously high for a programmable window before the domain is released, and a hold period follows that window. Loss of lock re-asserts reset and is counted. One instance sits beside each PLL output domain, e.g. the 100 MHz core domain and the 25 MHz video domain.

---
 rtl/pll_reset_sequencer.sv | 120 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Turns an asynchronous PLL locked flag into a clean synchronous reset
// and ready flag for one PLL output domain, counting lock losses.
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              soft_reset,
  input  logic              clear_losses,
  output logic              rst_out,
  output logic              ready,
  output logic [LOSS_W-1:0] lock_losses
);

  localparam int MAXC =
    (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = {LOSS_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT,
    STABLE,
    HOLD,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              s1, s2;
  logic              lock_s;
  logic              loss_event;
  logic [LOSS_W-1:0] losses_d;

  assign lock_s = s2;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    unique case (state_q)
      WAIT: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // a lost lock outranks a concurrent soft reset request
        if (!lock_s) begin
          state_d    = WAIT;
          cnt_d      = '0;
          loss_event = 1'b1;
        end else if (soft_reset) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // clear first, then count the loss so a coincident pair ends at 1
  always_comb begin
    losses_d = clear_losses ? '0 : lock_losses;
    if (loss_event && (losses_d != LOSS_MAX)) begin
      losses_d = losses_d + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state_q     <= WAIT;
      cnt_q       <= '0;
      rst_out     <= 1'b1;
      ready       <= 1'b0;
      lock_losses <= '0;
    end else begin
      s1          <= pll_locked;
      s2          <= s1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_out     <= (state_d != RUN);
      ready       <= (state_d == RUN);
      lock_losses <= losses_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed plus randomized bench for pll_reset_sequencer, checked
// against a run-length model of the lock/hold/soft-reset rules.
module tb_pll_reset_sequencer;

  localparam int S  = 4;
  localparam int H  = 2;
  localparam int LW = 2;
  localparam int WIN  = S + H + 1;
  localparam int LMAX = (1 << LW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          pll_locked;
  logic          soft_reset;
  logic          clear_losses;
  logic          rst_out;
  logic          ready;
  logic [LW-1:0] lock_losses;

  int checks   = 0;
  int failures = 0;

  logic [1:0] dl;
  int         run;
  int         pend;
  int         m_loss;
  logic       m_rst;

  pll_reset_sequencer #(
    .STABLE_CYCLES(S),
    .HOLD_CYCLES  (H),
    .LOSS_W       (LW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .soft_reset  (soft_reset),
    .clear_losses(clear_losses),
    .rst_out     (rst_out),
    .ready       (ready),
    .lock_losses (lock_losses)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // run: consecutive edges the synchronized flag has been seen high;
  // release needs S+H+1 such edges. pend: remaining soft-reset hold.
  task automatic step(input logic pl, input logic sr,
                      input logic cl, input logic rs);
    logic ls;
    logic was_run;
    pll_locked   = pl;
    soft_reset   = sr;
    clear_losses = cl;
    reset        = rs;
    @(posedge clock);
    if (rs) begin
      dl     = 2'b00;
      run    = 0;
      pend   = 0;
      m_loss = 0;
      m_rst  = 1'b1;
    end else begin
      ls      = dl[1];
      dl      = {dl[0], pl};
      was_run = !m_rst;
      if (!ls) begin
        run  = 0;
        pend = 0;
      end else begin
        if (run < WIN) run++;
        if (was_run && sr) pend = H;
        else if (pend > 0) pend--;
      end
      if (cl) m_loss = 0;
      if (was_run && !ls && m_loss < LMAX) m_loss++;
      m_rst = (run < WIN) || (pend > 0);
    end
    #1;
    chk("rst_out", 32'(rst_out), 32'(m_rst));
    chk("ready", 32'(ready), 32'(!m_rst));
    chk("lock_losses", 32'(lock_losses), 32'(m_loss));
  endtask

  task automatic relock();
    for (int i = 0; i < WIN + 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drop(input logic clr_on_loss);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, clr_on_loss, 1'b0);
  endtask

  initial begin
    pll_locked   = 1'b0;
    soft_reset   = 1'b0;
    clear_losses = 1'b0;
    reset        = 1'b1;
    dl = 2'b00; run = 0; pend = 0; m_loss = 0; m_rst = 1'b1;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_rst_out", 32'(rst_out), 32'd1);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_losses", 32'(lock_losses), 32'd0);

    // release latency, soft_reset held through WAIT/STABLE/HOLD
    for (int i = 0; i <= 8; i++) begin
      step(1'b1, (i < 8), 1'b0, 1'b0);
      chk("release_rst", 32'(rst_out), (i < 8) ? 32'd1 : 32'd0);
    end
    chk("release_ready", 32'(ready), 32'd1);

    // glitch during STABLE restarts the window
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("glitch_rst", 32'(rst_out), (i < 8) ? 32'd1 : 32'd0);
    end
    chk("glitch_losses", 32'(lock_losses), 32'd0);

    // loss in RUN shows on rst_out two edges after the first low sample
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("loss_e0", 32'(rst_out), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("loss_e1", 32'(rst_out), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("loss_e2", 32'(rst_out), 32'd1);
    chk("loss_count1", 32'(lock_losses), 32'd1);
    for (int i = 0; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("relock_rst", 32'(rst_out), (i < 8) ? 32'd1 : 32'd0);
    end

    // saturation, then clear together with a loss
    for (int k = 0; k < 3; k++) begin
      drop(1'b0);
      relock();
    end
    chk("loss_sat", 32'(lock_losses), 32'd3);
    drop(1'b0);
    relock();
    chk("loss_sat_hold", 32'(lock_losses), 32'd3);
    drop(1'b1);
    chk("clear_and_loss", 32'(lock_losses), 32'd1);
    relock();

    // soft reset pulse in RUN
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("soft_e0", 32'(rst_out), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("soft_e1", 32'(rst_out), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("soft_e2", 32'(rst_out), 32'd0);

    // soft reset coincident with a lock drop goes back to WAIT
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("soft_drop_losses", 32'(lock_losses), 32'd2);
    for (int i = 0; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("soft_drop_rst", 32'(rst_out), (i < 8) ? 32'd1 : 32'd0);
    end

    // reset while in RUN
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("run_reset_rst", 32'(rst_out), 32'd1);
    chk("run_reset_ready", 32'(ready), 32'd0);
    chk("run_reset_losses", 32'(lock_losses), 32'd0);

    // randomized phase: lock flips rarely so RUN is reached often
    begin
      logic pl;
      pl = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 19) == 0) pl = ~pl;
        step(pl,
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 199) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
